mont_expo_param: RTL



---
 rtl/mont_expo_param_if.sv | 28 ++
 rtl/mont_expo_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mont_expo_param_if.sv
// Request/response bundle for the modular exponentiator.
// Handshake: the requester raises start with x/e/n valid; the engine accepts
// on a rising clk edge where busy=0 (and reset=0). busy stays high from that
// accept edge until the edge that raises done. done is a one-cycle pulse and
// z/err are valid with it and held until the following done.
interface mont_expo_param_if #(
  parameter int WIDTH     = 192,
  parameter int EXP_WIDTH = 192
);
  logic                 start;
  logic [WIDTH-1:0]     x;
  logic [EXP_WIDTH-1:0] e;
  logic [WIDTH-1:0]     n;
  logic [WIDTH-1:0]     z;
  logic                 done;
  logic                 busy;
  logic                 err;

  modport master (
    output start, x, e, n,
    input  z, done, busy, err
  );

  modport slave (
    input  start, x, e, n,
    output z, done, busy, err
  );
endinterface

// File: rtl/mont_expo_param.sv
// Modular exponentiation z = x^e mod n, left-to-right square-and-multiply,
// built on a bit-serial interleaved modular multiplier (one multiplier bit
// per clock, multiplier operand scanned MSB first).
module mont_expo_param #(
  parameter int WIDTH      = 192,
  parameter int EXP_WIDTH  = 192,
  parameter bit CONST_TIME = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  mont_expo_param_if.slave bus,
  output logic [2:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  // The NEXT step (bit index advance) has no state of its own: it is folded
  // into the last cycle of SQR or MUL.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SQR   = 3'd2,
    S_MUL   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]     x_q, x_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     a_q, a_d;     // multiplicand (added when b bit set)
  logic [WIDTH-1:0]     b_q, b_d;     // multiplier, shifted left, MSB used
  logic [WIDTH+1:0]     r_q, r_d;     // partial product, always < n
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 bad_q, bad_d;
  logic [WIDTH-1:0]     z_q, z_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  // Control strobes from the output process
  logic accept;
  logic last_step;
  logic e_bit;
  logic go_mul;
  logic operand_bad;

  // Multiplier step datapath
  logic [WIDTH+1:0] n_ext, a_ext;
  logic [WIDTH+1:0] r_dbl, r_red, r_add, r_nxt;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] next_acc;

  // One interleaved multiplier step: R = 2R mod n, then R = R + a*b[i] mod n.
  always_comb begin
    n_ext = {2'b00, n_q};
    a_ext = {2'b00, a_q};
    r_dbl = r_q << 1;
    r_red = (r_dbl >= n_ext) ? (r_dbl - n_ext) : r_dbl;
    r_add = b_q[WIDTH-1] ? (r_red + a_ext) : r_red;
    r_nxt = (r_add >= n_ext) ? (r_add - n_ext) : r_add;
    prod  = r_nxt[WIDTH-1:0];
  end

  // State register; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CHECK;
      S_CHECK: state_d = operand_bad ? S_FIN : S_SQR;
      S_SQR: begin
        if (last_step) begin
          if (go_mul)               state_d = S_MUL;
          else if (idx_q == '0)     state_d = S_FIN;
          else                      state_d = S_SQR;
        end
      end
      S_MUL: begin
        if (last_step) state_d = (idx_q == '0) ? S_FIN : S_SQR;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/control decode from the current state.
  always_comb begin
    accept      = (state_q == S_IDLE) && bus.start;
    last_step   = ((state_q == S_SQR) || (state_q == S_MUL)) &&
                  (cnt_q == CW'(WIDTH - 1));
    e_bit       = e_q[idx_q];
    go_mul      = e_bit | CONST_TIME;
    operand_bad = (n_q < TWO) || (x_q >= n_q);
    // After SQR the square is always kept; after MUL the product is kept
    // only for a set exponent bit (constant-time dummy multiply otherwise).
    if (state_q == S_SQR) next_acc = prod;
    else                  next_acc = e_bit ? prod : acc_q;
    dbg_state_o = state_q;
  end

  // Datapath next values.
  always_comb begin
    x_d    = x_q;
    e_d    = e_q;
    n_d    = n_q;
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    bad_d  = bad_q;
    z_d    = z_q;
    done_d = 1'b0;
    busy_d = busy_q;
    err_d  = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d    = bus.x;
          e_d    = bus.e;
          n_d    = bus.n;
          busy_d = 1'b1;
        end
      end
      S_CHECK: begin
        bad_d = operand_bad;
        acc_d = ONE;
        idx_d = IW'(EXP_WIDTH - 1);
        r_d   = '0;
        cnt_d = '0;
        a_d   = ONE;
        b_d   = ONE;
      end
      S_SQR, S_MUL: begin
        r_d   = r_nxt;
        b_d   = b_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          r_d   = '0;
          cnt_d = '0;
          if ((state_q == S_SQR) && go_mul) begin
            acc_d = prod;
            a_d   = prod;
            b_d   = x_q;
          end else begin
            acc_d = next_acc;
            a_d   = next_acc;
            b_d   = next_acc;
            idx_d = idx_q - IW'(1);
          end
        end
      end
      S_FIN: begin
        z_d    = bad_q ? '0 : acc_q;
        err_d  = bad_q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      e_q    <= '0;
      n_q    <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      bad_q  <= 1'b0;
      z_q    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      e_q    <= e_d;
      n_q    <= n_d;
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      bad_q  <= bad_d;
      z_q    <= z_d;
      done_q <= done_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign bus.z    = z_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule
